// File: rtl/pipe_skid_reg.sv
`default_nettype none
// ============================================================================
// Module   : pipe_skid_reg
// Brief    : Elastic pipeline register for stage boundaries, with a 2-entry
//            skid buffer (main + skid) and valid/ready handshakes on both
//            sides. in_ready is registered, so no combinational ready path
//            crosses from downstream to upstream.
// Revision : 1.0 - initial release
// ============================================================================
module pipe_skid_reg #(
  parameter int NBIT = 12
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush_i,
  input  logic            in_valid_i,
  input  logic [NBIT-1:0] in_data_i,
  output logic            in_ready_o,
  output logic            out_valid_o,
  output logic [NBIT-1:0] out_data_o,
  input  logic            out_ready_i,
  output logic [1:0]      occupancy_o
);

  // The state encoding is the occupancy count, so occupancy_o reads it directly.
  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_BUSY  = 2'd1,
    S_FULL  = 2'd2
  } state_e;

  state_e            state_q;
  logic [NBIT-1:0]   main_q;
  logic [NBIT-1:0]   skid_q;
  logic              in_ready_q;
  logic              out_valid_q;

  logic              w_in_fire;
  logic              w_out_fire;

  assign w_in_fire  = in_valid_i  & in_ready_q;
  assign w_out_fire = out_valid_q & out_ready_i;

  assign in_ready_o  = in_ready_q;
  assign out_valid_o = out_valid_q;
  assign out_data_o  = main_q;
  assign occupancy_o = state_q;

  // Storage FSM: state, data registers and the registered handshake outputs.
  // Flush outranks every handshake; a word offered alongside it is dropped.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_EMPTY;
      main_q      <= '0;
      skid_q      <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else if (flush_i) begin
      state_q     <= S_EMPTY;
      main_q      <= '0;
      skid_q      <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        S_EMPTY: begin
          if (w_in_fire) begin
            state_q     <= S_BUSY;
            main_q      <= in_data_i;
            out_valid_q <= 1'b1;
            in_ready_q  <= 1'b1;
          end
        end
        S_BUSY: begin
          if (w_in_fire && w_out_fire) begin
            // Pass-through: the departing word is replaced in the same cycle.
            main_q <= in_data_i;
          end else if (w_in_fire) begin
            // Downstream stalled: park the new word behind the main entry.
            state_q    <= S_FULL;
            skid_q     <= in_data_i;
            in_ready_q <= 1'b0;
          end else if (w_out_fire) begin
            // main_q keeps its last value; out_valid qualifies it.
            state_q     <= S_EMPTY;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        S_FULL: begin
          // in_ready is low here, so only the drain side can move.
          if (w_out_fire) begin
            state_q    <= S_BUSY;
            main_q     <= skid_q;
            in_ready_q <= 1'b1;
          end
        end
        default: begin
          state_q     <= S_EMPTY;
          main_q      <= '0;
          skid_q      <= '0;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pipe_skid_reg.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_skid_reg
// Brief    : Self-checking bench for pipe_skid_reg. A queue-based model of a
//            2-deep FIFO predicts every output after every clock edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_skid_reg;

  localparam int NBIT = 12;

  logic            clk;
  logic            reset;
  logic            flush_i;
  logic            in_valid_i;
  logic [NBIT-1:0] in_data_i;
  logic            in_ready_o;
  logic            out_valid_o;
  logic [NBIT-1:0] out_data_o;
  logic            out_ready_i;
  logic [1:0]      occupancy_o;

  int n_checks;
  int n_errors;

  // Reference model: stored words oldest first, plus the last word shown.
  logic [NBIT-1:0] m_q[$];
  logic [NBIT-1:0] m_last;
  int              n_out_words;

  pipe_skid_reg #(.NBIT(NBIT)) dut (
    .clk         (clk),
    .reset       (reset),
    .flush_i     (flush_i),
    .in_valid_i  (in_valid_i),
    .in_data_i   (in_data_i),
    .in_ready_o  (in_ready_o),
    .out_valid_o (out_valid_o),
    .out_data_o  (out_data_o),
    .out_ready_i (out_ready_i),
    .occupancy_o (occupancy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int unsigned got, input int unsigned exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    m_q.delete();
    m_last = '0;
  endtask

  // Compare all DUT outputs against the model's view of the FIFO.
  task automatic check_model(input string tag);
    check_eq({tag, ".occ"},   32'(occupancy_o), 32'(m_q.size()));
    check_eq({tag, ".rdy"},   32'(in_ready_o),  32'(m_q.size() < 2));
    check_eq({tag, ".vld"},   32'(out_valid_o), 32'(m_q.size() > 0));
    check_eq({tag, ".data"},  32'(out_data_o),  32'(m_last));
  endtask

  // One clock: drive inputs, apply the edge to the model, check 1 ns later.
  task automatic step(input logic v, input logic [NBIT-1:0] d, input logic rdy,
                      input logic fl, input string tag);
    bit in_fire;
    bit out_fire;
    in_valid_i  = v;
    in_data_i   = d;
    out_ready_i = rdy;
    flush_i     = fl;
    @(posedge clk);
    in_fire  = v && (m_q.size() < 2);
    out_fire = rdy && (m_q.size() > 0);
    if (fl) begin
      if (out_fire) n_out_words++;
      model_clear();
    end else begin
      if (out_fire) begin
        void'(m_q.pop_front());
        n_out_words++;
      end
      if (in_fire) m_q.push_back(d);
      if (m_q.size() > 0) m_last = m_q[0];
    end
    #1;
    check_model(tag);
  endtask

  initial begin
    n_checks    = 0;
    n_errors    = 0;
    n_out_words = 0;
    model_clear();
    reset       = 1'b0;
    flush_i     = 1'b0;
    in_valid_i  = 1'b1;
    in_data_i   = 12'h3C3;
    out_ready_i = 1'b1;

    // 1: reset held across edges with in_valid asserted.
    repeat (3) @(posedge clk);
    #1;
    check_eq("reset.vld",  32'(out_valid_o), 32'd0);
    check_eq("reset.rdy",  32'(in_ready_o),  32'd1);
    check_eq("reset.data", 32'(out_data_o),  32'd0);
    check_eq("reset.occ",  32'(occupancy_o), 32'd0);
    reset      = 1'b1;
    in_valid_i = 1'b0;

    // 2: streaming at full rate, one cycle latency.
    for (int i = 1; i <= 10; i++) begin
      step(1'b1, NBIT'(i), 1'b1, 1'b0, "stream");
      check_eq("stream.word", 32'(out_data_o), 32'(i));
      check_eq("stream.occ1", 32'(occupancy_o), 32'd1);
    end
    step(1'b0, 12'h000, 1'b1, 1'b0, "drain");

    // 3: backpressure fills the skid entry, then drains in order.
    step(1'b1, 12'h0A5, 1'b1, 1'b0, "bp_load");
    step(1'b1, 12'h05A, 1'b0, 1'b0, "bp_fill");
    check_eq("bp.occ2",  32'(occupancy_o), 32'd2);
    check_eq("bp.rdy0",  32'(in_ready_o),  32'd0);
    check_eq("bp.head",  32'(out_data_o),  32'h0A5);
    step(1'b1, 12'h777, 1'b0, 1'b0, "bp_stall");
    step(1'b0, 12'h000, 1'b1, 1'b0, "bp_rel1");
    check_eq("bp.second", 32'(out_data_o), 32'h05A);
    check_eq("bp.rdy1",   32'(in_ready_o), 32'd1);
    step(1'b0, 12'h000, 1'b1, 1'b0, "bp_rel2");
    check_eq("bp.empty",  32'(out_valid_o), 32'd0);
    check_eq("bp.hold",   32'(out_data_o),  32'h05A);

    // 4: flush while FULL with a coincident upstream word.
    step(1'b1, 12'h111, 1'b0, 1'b0, "fl_a");
    step(1'b1, 12'h222, 1'b0, 1'b0, "fl_b");
    step(1'b1, 12'hFFF, 1'b0, 1'b1, "fl_do");
    check_eq("flush.occ",  32'(occupancy_o), 32'd0);
    check_eq("flush.vld",  32'(out_valid_o), 32'd0);
    check_eq("flush.data", 32'(out_data_o),  32'd0);
    step(1'b0, 12'h000, 1'b1, 1'b0, "fl_after");
    check_eq("flush.no_fff", 32'(out_valid_o), 32'd0);

    // 5: asynchronous reset between edges while BUSY.
    step(1'b1, 12'h123, 1'b0, 1'b0, "ar_load");
    in_valid_i = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    model_clear();
    check_eq("areset.vld", 32'(out_valid_o), 32'd0);
    check_eq("areset.occ", 32'(occupancy_o), 32'd0);
    check_eq("areset.rdy", 32'(in_ready_o),  32'd1);
    check_eq("areset.data", 32'(out_data_o), 32'd0);
    reset = 1'b1;

    // 6: random valid/ready with occasional flush.
    for (int c = 0; c < 10000; c++) begin
      step(1'($urandom_range(0, 99) < 60), NBIT'($urandom), 1'($urandom_range(0, 99) < 55),
           1'($urandom_range(0, 199) == 0), "rand");
    end
    check_eq("rand.progress", 32'(n_out_words > 2000), 32'd1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
